// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM states
//   npc_sel_t        : which source supplies the next PC
//   RESET_PC_DEFAULT : default byte address loaded into the PC on reset
package pc_fetch_unit_pkg;

   typedef enum logic [1:0] {
      RST,
      REQ,
      HOLD
   } fetch_state_t;

   typedef enum logic [1:0] {
      NPC_SEQ,
      NPC_BR,
      NPC_JMP,
      NPC_JR
   } npc_sel_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Branch targets arrive word-granular; convert to a byte address.
   function automatic logic [31:0] word_to_byte(input logic [31:0] w);
      return {w[29:0], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC priority mux (jr > jmp > branch_taken).
//   pc_plus_4    in  : sequential PC, also supplies the jump region bits
//   branch_taken in  : branch redirect request
//   branch_addr  in  : word-granular branch target
//   jmp          in  : J/JAL redirect request
//   jump_index   in  : J-format index
//   jr           in  : register-indirect redirect request
//   jr_addr      in  : jr target (low two bits ignored)
//   sel          out : selected source; NPC_SEQ means no redirect
//   target       out : byte address of the selected next PC
module pc_fetch_unit_next_pc_sel
   import pc_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus_4,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   input  logic        jmp,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output npc_sel_t    sel,
   output logic [31:0] target
);

   // Bits that are architecturally discarded by the target formats.
   logic unused_bits;
   assign unused_bits = ^{branch_addr[31:30], jr_addr[1:0]};

   always_comb begin
      sel    = NPC_SEQ;
      target = pc_plus_4;
      if (jr) begin
         sel    = NPC_JR;
         target = {jr_addr[31:2], 2'b00};
      end else if (jmp) begin
         sel    = NPC_JMP;
         target = {pc_plus_4[31:28], jump_index, 2'b00};
      end else if (branch_taken) begin
         sel    = NPC_BR;
         target = word_to_byte(branch_addr);
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake and a
// single-entry valid/ready output to decode, plus redirect handling.
//   clock, reset_n             : clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata    : instruction memory handshake
//   instr_valid/ready/out/pc   : fetched instruction towards decode
//   pc_plus_4                  : pc + 4, combinational
//   stall                      : hazard hold, blocks acceptance in HOLD
//   branch_taken/branch_addr   : branch redirect (word-granular target)
//   jmp/jal/jump_index         : J/JAL redirect, jal captures link_addr
//   jr/jr_addr                 : register-indirect redirect
//   link_addr                  : instr_pc + 4 captured on jal
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_AW  = 14
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [31:0]        instr_out,
   output logic [31:0]        instr_pc,
   output logic [31:0]        pc_plus_4,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_addr,
   input  logic               jmp,
   input  logic               jal,
   input  logic [25:0]        jump_index,
   input  logic               jr,
   input  logic [31:0]        jr_addr,
   output logic [31:0]        link_addr
);

   fetch_state_t       state, state_d;
   logic [31:0]        pc, pc_d;
   logic               pend, pend_d;
   logic [IMEM_AW-1:0] hold_addr, hold_addr_d;
   logic               capture;
   logic               link_en;
   logic               redirect;
   npc_sel_t           npc_sel;
   logic [31:0]        npc_target;

   assign pc_plus_4 = pc + 32'd4;

   pc_fetch_unit_next_pc_sel u_next_pc_sel (
      .pc_plus_4    (pc_plus_4),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .jmp          (jmp),
      .jump_index   (jump_index),
      .jr           (jr),
      .jr_addr      (jr_addr),
      .sel          (npc_sel),
      .target       (npc_target)
   );

   assign redirect = (npc_sel != NPC_SEQ) && (state != RST);
   assign link_en  = jmp && jal && (state != RST);

   // While a redirect is pending the PC already holds the new target, so the
   // outstanding request keeps presenting the address latched in hold_addr.
   assign imem_req    = (state == REQ);
   assign imem_addr   = pend ? hold_addr : pc[IMEM_AW+1:2];
   assign instr_valid = (state == HOLD);

   always_comb begin
      state_d     = state;
      pc_d        = pc;
      pend_d      = pend;
      hold_addr_d = hold_addr;
      capture     = 1'b0;
      case (state)
         RST: state_d = REQ;
         REQ: begin
            if (redirect) begin
               pc_d = npc_target;
               if (imem_ack) begin
                  // Returned data belongs to the abandoned path.
                  pend_d = 1'b0;
               end else begin
                  if (!pend) hold_addr_d = pc[IMEM_AW+1:2];
                  pend_d = 1'b1;
               end
            end else if (imem_ack) begin
               if (pend) begin
                  pend_d = 1'b0;
               end else begin
                  capture = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = npc_target;
               state_d = REQ;
            end else if (instr_ready && !stall) begin
               pc_d    = pc_plus_4;
               state_d = REQ;
            end
         end
         default: state_d = RST;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RST;
         pc        <= RESET_PC;
         pend      <= 1'b0;
         hold_addr <= '0;
         instr_out <= '0;
         instr_pc  <= '0;
         link_addr <= '0;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         pend      <= pend_d;
         hold_addr <= hold_addr_d;
         if (capture) begin
            instr_out <= imem_rdata;
            instr_pc  <= pc;
         end
         if (link_en) link_addr <= instr_pc + 32'd4;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned AW     = 14;
   localparam int unsigned TMO    = 50;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [31:0]   imem_rdata = '0;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic [31:0]   instr_out;
   logic [31:0]   instr_pc;
   logic [31:0]   pc_plus_4;
   logic          stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [31:0]   branch_addr = '0;
   logic          jmp = 1'b0;
   logic          jal = 1'b0;
   logic [25:0]   jump_index = '0;
   logic          jr = 1'b0;
   logic [31:0]   jr_addr = '0;
   logic [31:0]   link_addr;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   fetch_t      exp_q[$];
   int unsigned ack_lat = 0;
   int unsigned req_age = 0;

   pc_fetch_unit #(.RESET_PC(RST_PC), .IMEM_AW(AW)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_out    (instr_out),
      .instr_pc     (instr_pc),
      .pc_plus_4    (pc_plus_4),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .jmp          (jmp),
      .jal          (jal),
      .jump_index   (jump_index),
      .jr           (jr),
      .jr_addr      (jr_addr),
      .link_addr    (link_addr)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return 32'h5A00_0000 | {18'd0, a};
   endfunction

   function automatic logic [AW-1:0] waddr(input logic [31:0] p);
      return p[AW+1:2];
   endfunction

   // Memory model: acks a request ack_lat cycles after it is first seen.
   always @(negedge clock) begin
      if (imem_req && reset_n) begin
         if (req_age >= ack_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            req_age    = 0;
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            req_age    = req_age + 1;
         end
      end else begin
         imem_ack = 1'b0;
         req_age  = 0;
      end
   end

   task automatic wait_valid(output bit ok);
      int unsigned t;
      t = 0;
      while (!instr_valid && t < TMO) begin
         @(negedge clock);
         t++;
      end
      ok = instr_valid;
   endtask

   // Steers the fetch unit (via jr from HOLD) until it holds the
   // instruction at tgt; leaves instr_ready low.
   task automatic go_hold(input logic [31:0] tgt, output bit ok);
      bit ok1;
      wait_valid(ok1);
      jr = 1'b1;
      jr_addr = tgt;
      @(negedge clock);
      jr = 1'b0;
      wait_valid(ok);
      ok = ok && ok1;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
      n_cmp++; if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h/%h want 0/0", instr_out, instr_pc); end
      n_cmp++; if (link_addr !== 32'h0) begin n_err++; $display("FAIL rst_link: got %h want 0", link_addr); end
      n_cmp++; if (pc_plus_4 !== RST_PC + 32'd4) begin n_err++; $display("FAIL rst_pc4: got %h want %h", pc_plus_4, RST_PC + 32'd4); end
      reset_n = 1'b1;
      @(negedge clock);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== waddr(RST_PC)) begin n_err++; $display("FAIL rst_first_req: got %b/%h want 1/%h", imem_req, imem_addr, waddr(RST_PC)); end
   endtask

   task automatic test_sequential;
      fetch_t      e;
      int unsigned got, t, last;
      ack_lat = 0;
      instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) exp_q.push_back({RST_PC + 32'd4 * k, mem_word(waddr(RST_PC + 32'd4 * k))});
      got = 0; t = 0; last = 0;
      while (got < 6 && t < TMO) begin
         if (imem_req) begin
            n_cmp++;
            if (imem_addr !== waddr(RST_PC + 32'd4 * got)) begin n_err++; $display("FAIL seq_addr: got %h want %h", imem_addr, waddr(RST_PC + 32'd4 * got)); end
         end
         if (instr_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (instr_pc !== e.pc || instr_out !== e.instr || pc_plus_4 !== e.pc + 32'd4) begin
               n_err++; $display("FAIL seq_fetch: got pc %h instr %h pc4 %h want %h %h %h", instr_pc, instr_out, pc_plus_4, e.pc, e.instr, e.pc + 32'd4);
            end
            if (got > 0) begin
               n_cmp++;
               if (t - last != 2) begin n_err++; $display("FAIL seq_cadence: got %0d cycles want 2", t - last); end
            end
            last = t;
            got++;
         end
         @(negedge clock);
         t++;
      end
      n_cmp++; if (got != 6) begin n_err++; $display("FAIL seq_timeout: got %0d fetches want 6", got); end
      instr_ready = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_branch_redirect;
      fetch_t e;
      bit     ok;
      go_hold(32'h40, ok);
      exp_q.push_back({32'h40, mem_word(waddr(32'h40))});
      e = exp_q.pop_front();
      n_cmp++; if (!ok || instr_pc !== e.pc || instr_out !== e.instr) begin n_err++; $display("FAIL br_setup: got %b pc %h want pc %h", ok, instr_pc, e.pc); end
      branch_taken = 1'b1;
      branch_addr = 32'h20;
      exp_q.push_back({32'h80, mem_word(14'h20)});
      @(negedge clock);
      branch_taken = 1'b0;
      n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_kill: got valid %b want 0", instr_valid); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 14'h20) begin n_err++; $display("FAIL br_addr: got %b/%h want 1/%h", imem_req, imem_addr, 14'h20); end
      wait_valid(ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || instr_pc !== e.pc || instr_out !== e.instr) begin n_err++; $display("FAIL br_fetch: got pc %h instr %h want %h %h", instr_pc, instr_out, e.pc, e.instr); end
   endtask

   task automatic test_req_redirect;
      fetch_t      e;
      bit          ok;
      int unsigned stay;
      ack_lat = 3;
      jr = 1'b1;
      jr_addr = 32'h10;
      @(negedge clock);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 14'h4) begin n_err++; $display("FAIL rq_start: got %b/%h want 1/4", imem_req, imem_addr); end
      jr_addr = 32'h103;
      exp_q.push_back({32'h100, mem_word(14'h40)});
      @(negedge clock);
      jr = 1'b0;
      stay = 0;
      while (imem_addr === 14'h4 && stay < TMO) begin
         n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rq_discard: got valid %b want 0", instr_valid); end
         stay++;
         @(negedge clock);
      end
      n_cmp++; if (stay != ack_lat) begin n_err++; $display("FAIL rq_hold_cycles: got %0d want %0d", stay, ack_lat); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 14'h40 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rq_new_addr: got %b/%h v%b want 1/40 v0", imem_req, imem_addr, instr_valid); end
      wait_valid(ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || instr_pc !== e.pc || instr_out !== e.instr) begin n_err++; $display("FAIL rq_fetch: got pc %h instr %h want %h %h", instr_pc, instr_out, e.pc, e.instr); end
      ack_lat = 0;
   endtask

   task automatic test_priority;
      fetch_t e;
      bit     ok;
      jr = 1'b1;
      jr_addr = 32'h200;
      branch_taken = 1'b1;
      branch_addr = 32'h99;
      exp_q.push_back({32'h200, mem_word(14'h80)});
      @(negedge clock);
      jr = 1'b0;
      branch_taken = 1'b0;
      n_cmp++; if (imem_addr !== 14'h80) begin n_err++; $display("FAIL pri_addr: got %h want 80", imem_addr); end
      wait_valid(ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || instr_pc !== e.pc || instr_out !== e.instr) begin n_err++; $display("FAIL pri_fetch: got pc %h want %h", instr_pc, e.pc); end
      go_hold(32'h3C, ok);
      n_cmp++; if (!ok || instr_pc !== 32'h3C) begin n_err++; $display("FAIL jal_setup: got pc %h want 3c", instr_pc); end
      jmp = 1'b1;
      jal = 1'b1;
      jump_index = 26'h123;
      exp_q.push_back({32'h48C, mem_word(14'h123)});
      @(negedge clock);
      jmp = 1'b0;
      jal = 1'b0;
      n_cmp++; if (link_addr !== 32'h40) begin n_err++; $display("FAIL jal_link: got %h want 40", link_addr); end
      n_cmp++; if (imem_addr !== 14'h123) begin n_err++; $display("FAIL jmp_addr: got %h want 123", imem_addr); end
      wait_valid(ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || instr_pc !== e.pc || instr_out !== e.instr) begin n_err++; $display("FAIL jmp_fetch: got pc %h want %h", instr_pc, e.pc); end
   endtask

   task automatic test_stall;
      fetch_t e;
      bit     ok;
      stall = 1'b1;
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         n_cmp++;
         if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 32'h48C || instr_out !== mem_word(14'h123)) begin
            n_err++; $display("FAIL stall_hold: got v%b r%b pc %h instr %h want v1 r0 pc 48c", instr_valid, imem_req, instr_pc, instr_out);
         end
      end
      stall = 1'b0;
      exp_q.push_back({32'h490, mem_word(14'h124)});
      @(negedge clock);
      instr_ready = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 14'h124 || pc_plus_4 !== 32'h494) begin n_err++; $display("FAIL stall_release: got %b/%h pc4 %h want 1/124 494", imem_req, imem_addr, pc_plus_4); end
      wait_valid(ok);
      e = exp_q.pop_front();
      n_cmp++; if (!ok || instr_pc !== e.pc || instr_out !== e.instr) begin n_err++; $display("FAIL stall_fetch: got pc %h want %h", instr_pc, e.pc); end
   endtask

   task automatic test_wrap_and_reset;
      fetch_t e;
      bit     ok;
      go_hold(32'hFFFF_FFFC, ok);
      n_cmp++; if (!ok || instr_pc !== 32'hFFFF_FFFC || pc_plus_4 !== 32'h0) begin n_err++; $display("FAIL wrap_hold: got pc %h pc4 %h want fffffffc 0", instr_pc, pc_plus_4); end
      ack_lat = 5;
      instr_ready = 1'b1;
      @(negedge clock);
      instr_ready = 1'b0;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 14'h0 || pc_plus_4 !== 32'h4) begin n_err++; $display("FAIL wrap_pc: got %b/%h pc4 %h want 1/0 4", imem_req, imem_addr, pc_plus_4); end
      jr = 1'b1;
      jr_addr = 32'h500;
      @(negedge clock);
      jr = 1'b0;
      n_cmp++; if (pc_plus_4 !== 32'h504 || imem_addr !== 14'h0) begin n_err++; $display("FAIL pend_setup: got pc4 %h addr %h want 504 0", pc_plus_4, imem_addr); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_plus_4 !== RST_PC + 32'd4 || link_addr !== 32'h0) begin
         n_err++; $display("FAIL async_reset: got req %b v %b pc4 %h link %h want 0 0 %h 0", imem_req, instr_valid, pc_plus_4, link_addr, RST_PC + 32'd4);
      end
      ack_lat = 0;
      @(negedge clock);
      reset_n = 1'b1;
      exp_q.push_back({RST_PC, mem_word(waddr(RST_PC))});
      @(negedge clock);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== waddr(RST_PC)) begin n_err++; $display("FAIL rerst_req: got %b/%h want 1/%h", imem_req, imem_addr, waddr(RST_PC)); end
      @(negedge clock);
      e = exp_q.pop_front();
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr_out !== e.instr) begin n_err++; $display("FAIL rerst_fetch: got v%b pc %h instr %h want v1 %h %h", instr_valid, instr_pc, instr_out, e.pc, e.instr); end
   endtask

   initial begin
      test_reset;
      test_sequential;
      test_branch_redirect;
      test_req_redirect;
      test_priority;
      test_stall;
      test_wrap_and_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
